// File: rtl/mult_pkg.sv
// Shared definitions for the shift-add multiplier: FSM states, the rescale
// constant shared with the divider, and a constant-width helper.
package mult_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int DIV_CONST = 26;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 32; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/mult_step.sv
// One shift-add step: conditionally accumulate the shifted multiplicand,
// then advance both operand shifters by one bit.
module mult_step #(
    parameter int WIDTH  = 56,
    parameter int MWIDTH = 8
) (
    input  logic [WIDTH+MWIDTH-1:0] acc,
    input  logic [WIDTH+MWIDTH-1:0] a_sh,
    input  logic [MWIDTH-1:0]       b_sh,
    output logic [WIDTH+MWIDTH-1:0] acc_next,
    output logic [WIDTH+MWIDTH-1:0] a_sh_next,
    output logic [MWIDTH-1:0]       b_sh_next
);

    // acc is wide enough for the full product, so this add never wraps.
    always_comb begin
        acc_next  = b_sh[0] ? (acc + a_sh) : acc;
        a_sh_next = a_sh << 1;
        b_sh_next = b_sh >> 1;
    end

endmodule

// File: rtl/mult_seq.sv
// Iterative unsigned multiplier, one multiplier bit per clock, with
// valid/ready operand intake and result delivery plus overflow flag.
//
// state | meaning
// IDLE  | waiting for operands, in_ready high
// RUN   | MWIDTH shift-add steps, inputs ignored
// DONE  | result held with out_valid high until out_ready
module mult_seq
    import mult_pkg::*;
#(
    parameter int WIDTH    = 56,
    parameter int MWIDTH   = 8,
    parameter int SATURATE = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WIDTH-1:0]  a,
    input  logic [MWIDTH-1:0] b,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [WIDTH-1:0]  res,
    output logic              ovf
);

    localparam int AW = WIDTH + MWIDTH;
    localparam int CW = clog2(MWIDTH + 1);

    state_t            state_q, state_d;
    logic [AW-1:0]     acc_q, acc_d;
    logic [AW-1:0]     a_sh_q, a_sh_d;
    logic [MWIDTH-1:0] b_sh_q, b_sh_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [WIDTH-1:0]  res_q, res_d;
    logic              ovf_q, ovf_d;
    logic              in_ready_q, in_ready_d;
    logic              out_valid_q, out_valid_d;

    logic [AW-1:0]     acc_nx;
    logic [AW-1:0]     a_sh_nx;
    logic [MWIDTH-1:0] b_sh_nx;
    logic              ovf_nx;

    mult_step #(
        .WIDTH  (WIDTH),
        .MWIDTH (MWIDTH)
    ) u_step (
        .acc       (acc_q),
        .a_sh      (a_sh_q),
        .b_sh      (b_sh_q),
        .acc_next  (acc_nx),
        .a_sh_next (a_sh_nx),
        .b_sh_next (b_sh_nx)
    );

    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        a_sh_d      = a_sh_q;
        b_sh_d      = b_sh_q;
        cnt_d       = cnt_q;
        res_d       = res_q;
        ovf_d       = ovf_q;
        in_ready_d  = in_ready_q;
        out_valid_d = out_valid_q;
        ovf_nx      = |acc_nx[AW-1:WIDTH];

        case (state_q)
            IDLE: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                if (in_valid) begin
                    a_sh_d     = {{MWIDTH{1'b0}}, a};
                    b_sh_d     = b;
                    acc_d      = '0;
                    cnt_d      = CW'(MWIDTH);
                    in_ready_d = 1'b0;
                    state_d    = RUN;
                end
            end
            RUN: begin
                acc_d  = acc_nx;
                a_sh_d = a_sh_nx;
                b_sh_d = b_sh_nx;
                cnt_d  = cnt_q - CW'(1);
                // Fixed latency: no early exit when the multiplier runs out of ones.
                if (cnt_q == CW'(1)) begin
                    ovf_d       = ovf_nx;
                    res_d       = ((SATURATE != 0) && ovf_nx) ? '1 : acc_nx[WIDTH-1:0];
                    out_valid_d = 1'b1;
                    state_d     = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    out_valid_d = 1'b0;
                    in_ready_d  = 1'b1;
                    state_d     = IDLE;
                end
            end
            default: begin
                in_ready_d  = 1'b1;
                out_valid_d = 1'b0;
                state_d     = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            acc_q       <= '0;
            a_sh_q      <= '0;
            b_sh_q      <= '0;
            cnt_q       <= '0;
            res_q       <= '0;
            ovf_q       <= 1'b0;
            in_ready_q  <= 1'b1;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            a_sh_q      <= a_sh_d;
            b_sh_q      <= b_sh_d;
            cnt_q       <= cnt_d;
            res_q       <= res_d;
            ovf_q       <= ovf_d;
            in_ready_q  <= in_ready_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign res       = res_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_mult_seq.sv
// Bench for mult_seq: truncating and saturating instances share stimulus and
// are compared against an arithmetic product model.
module tb_mult_seq;
    import mult_pkg::*;

    localparam int W = 56;
    localparam int M = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         in_valid = 1'b0;
    logic [W-1:0] a = '0;
    logic [M-1:0] b = '0;
    logic         out_ready = 1'b0;

    logic         in_ready0, out_valid0, ovf0;
    logic         in_ready1, out_valid1, ovf1;
    logic [W-1:0] res0, res1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mult_seq #(.WIDTH(W), .MWIDTH(M), .SATURATE(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .a(a), .b(b), .out_valid(out_valid0), .out_ready(out_ready),
        .res(res0), .ovf(ovf0)
    );

    mult_seq #(.WIDTH(W), .MWIDTH(M), .SATURATE(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .a(a), .b(b), .out_valid(out_valid1), .out_ready(out_ready),
        .res(res1), .ovf(ovf1)
    );

    function automatic bit ref_ovf(input logic [W-1:0] av, input logic [M-1:0] bv);
        logic [127:0] p;
        p = 128'(av) * 128'(bv);
        return p >= (128'(1) << W);
    endfunction

    function automatic logic [W-1:0] ref_res(input logic [W-1:0] av, input logic [M-1:0] bv,
                                             input bit sat);
        logic [127:0] p;
        p = 128'(av) * 128'(bv);
        if (sat && ref_ovf(av, bv)) return '1;
        return p[W-1:0];
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_result(input string tag, input logic [W-1:0] av, input logic [M-1:0] bv);
        check({tag, "_res0"}, 64'(res0), 64'(ref_res(av, bv, 1'b0)));
        check({tag, "_res1"}, 64'(res1), 64'(ref_res(av, bv, 1'b1)));
        check({tag, "_ovf0"}, 64'(ovf0), 64'(ref_ovf(av, bv)));
        check({tag, "_ovf1"}, 64'(ovf1), 64'(ref_ovf(av, bv)));
    endtask

    // Present one operand pair, expect the result exactly M edges later, and
    // optionally hold off the consumer for 'stall' cycles while poking in_valid.
    task automatic run_op(input string tag, input logic [W-1:0] av, input logic [M-1:0] bv,
                          input int stall);
        int  lat;
        bit  busy_ok;
        check({tag, "_in_ready_pre"}, 64'(in_ready0), 64'd1);
        in_valid  = 1'b1;
        a         = av;
        b         = bv;
        out_ready = (stall == 0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        a        = '1;
        b        = '1;
        lat      = 0;
        busy_ok  = 1'b1;
        while (out_valid0 !== 1'b1 && lat < 40) begin
            if (in_ready0 !== 1'b0) busy_ok = 1'b0;
            @(posedge clk); #1;
            lat++;
        end
        check({tag, "_latency"}, 64'(lat), 64'(M));
        check({tag, "_in_ready_busy"}, 64'(busy_ok), 64'd1);
        check({tag, "_in_ready_done"}, 64'(in_ready0), 64'd0);
        check_result(tag, av, bv);
        if (stall > 0) begin
            bit stable_ok;
            stable_ok = 1'b1;
            for (int i = 0; i < stall; i++) begin
                in_valid = (i % 3 == 0);
                a        = W'(i + 5);
                b        = M'(i + 1);
                @(posedge clk); #1;
                if (out_valid0 !== 1'b1 || in_ready0 !== 1'b0 ||
                    res0 !== ref_res(av, bv, 1'b0) || res1 !== ref_res(av, bv, 1'b1))
                    stable_ok = 1'b0;
            end
            in_valid = 1'b0;
            check({tag, "_stall_stable"}, 64'(stable_ok), 64'd1);
            out_ready = 1'b1;
        end
        @(posedge clk); #1;
        check({tag, "_out_valid_after"}, 64'(out_valid0), 64'd0);
        check({tag, "_in_ready_after"}, 64'(in_ready0), 64'd1);
        check({tag, "_res_kept"}, 64'(res0), 64'(ref_res(av, bv, 1'b0)));
        @(posedge clk); #1;
        check({tag, "_no_second"}, 64'(out_valid0), 64'd0);
    endtask

    initial begin
        logic [W-1:0] cur_a;
        logic [M-1:0] cur_b;
        logic [W-1:0] qa[$];
        logic [M-1:0] qb[$];
        int           acc_cnt;
        int           res_cnt;
        int           cyc;
        bit           in_hs;
        bit           out_hs;
        bit           quiet_ok;

        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready", 64'(in_ready0), 64'd1);
        check("rst_out_valid", 64'(out_valid0), 64'd0);
        check("rst_res", 64'(res0), 64'd0);
        check("rst_ovf", 64'(ovf0), 64'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run_op("basic", W'(3), M'(DIV_CONST), 0);
        run_op("ovf_pow", W'(1) << (W - 1), M'(2), 0);
        run_op("b_zero", 56'h00FF_FFFF_FFFF_FFFF, M'(0), 0);
        run_op("a_zero", W'(0), M'(255), 0);
        run_op("max_max", '1, '1, 0);
        run_op("stall", W'(1000), M'(DIV_CONST), 20);

        // Abort mid-run: reset must clear everything and suppress the result.
        in_valid = 1'b1;
        a        = W'(5);
        b        = M'(DIV_CONST);
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        check("abort_out_valid", 64'(out_valid0), 64'd0);
        check("abort_res", 64'(res0), 64'd0);
        check("abort_ovf", 64'(ovf0), 64'd0);
        check("abort_in_ready", 64'(in_ready0), 64'd1);
        #1;
        rst_n = 1'b1;
        quiet_ok = 1'b1;
        repeat (12) begin
            @(posedge clk); #1;
            if (out_valid0 !== 1'b0) quiet_ok = 1'b0;
        end
        check("abort_no_result", 64'(quiet_ok), 64'd1);
        run_op("after_abort", W'(7), M'(DIV_CONST), 0);

        // Back-to-back random traffic with random consumer backpressure.
        acc_cnt = 0;
        res_cnt = 0;
        cyc     = 0;
        cur_a   = {$urandom, $urandom} >> 8;
        cur_b   = M'($urandom_range(0, 255));
        a       = cur_a;
        b       = cur_b;
        while ((acc_cnt < 50 || res_cnt < acc_cnt) && cyc < 3000) begin
            in_valid  = (acc_cnt < 50);
            out_ready = $urandom_range(0, 1) == 1;
            in_hs     = in_valid && in_ready0;
            out_hs    = out_valid0 && out_ready;
            if (out_hs) begin
                if (qa.size() == 0) begin
                    check("rnd_extra_result", 64'd1, 64'd0);
                end else begin
                    check_result("rnd", qa.pop_front(), qb.pop_front());
                end
                res_cnt++;
            end
            if (in_hs) begin
                qa.push_back(cur_a);
                qb.push_back(cur_b);
                acc_cnt++;
                case ($urandom_range(0, 3))
                    0: cur_a = W'($urandom_range(0, 5000));
                    1: cur_a = '1;
                    default: cur_a = {$urandom, $urandom} >> 8;
                endcase
                cur_b = ($urandom_range(0, 3) == 0) ? M'(DIV_CONST) : M'($urandom_range(0, 255));
            end
            @(posedge clk); #1;
            a = cur_a;
            b = cur_b;
            cyc++;
        end
        in_valid = 1'b0;
        check("rnd_accepted", 64'(acc_cnt), 64'd50);
        check("rnd_results", 64'(res_cnt), 64'd50);
        check("rnd_queue_empty", 64'(qa.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
